// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot controllers: state/display codes and default capacity.
// Display codes match the entry controller's, so the operator panel decodes both the same way.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'b000,
        WAIT_TICKET = 3'b001,
        EXIT_OPEN   = 3'b010,
        REJECT      = 3'b011,
        TIMEOUT     = 3'b100
    } exit_state_e;

    localparam int unsigned DEFAULT_CAPACITY = 8;

endpackage

// File: rtl/parking_occupancy_counter.sv
// Lot occupancy counter: +1 on inc unless full, -1 on dec unless empty,
// and no change when both arrive on the same edge.
module parking_occupancy_counter #(
    parameter int unsigned CAPACITY = 8,
    parameter int unsigned OCC_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [OCC_W-1:0] count_q, count_d;

    assign full  = (count_q == OCC_W'(CAPACITY));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + OCC_W'(1);
        end else if (dec && !inc && !empty) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/parking_exit_controller.sv
// Exit-side parking controller: ticket handshake FSM with timeout, barrier/LED drive,
// and ownership of the lot occupancy count.
module parking_exit_controller
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY       = DEFAULT_CAPACITY,
    parameter int unsigned OCC_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMER_W        = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inner_sensor,
    input  logic             outer_sensor,
    input  logic             ticket_valid,
    input  logic             ticket_ok,
    input  logic             entry_event,
    output logic             ticket_ready,
    output logic             barrier_open,
    output logic             green_LED,
    output logic             red_LED,
    output logic [2:0]       display_screen,
    output logic [OCC_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty
);

    exit_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timer_max;
    logic               exit_done;

    assign timer_max = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        exit_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (inner_sensor && !lot_empty) state_d = WAIT_TICKET;
            end
            WAIT_TICKET: begin
                if (ticket_valid && ticket_ok)       state_d = EXIT_OPEN;
                else if (ticket_valid && !ticket_ok) state_d = REJECT;
                else if (!inner_sensor)              state_d = IDLE;
                else if (timer_max)                  state_d = TIMEOUT;
            end
            REJECT: begin
                if (ticket_valid && ticket_ok) state_d = EXIT_OPEN;
                else if (!inner_sensor)        state_d = IDLE;
            end
            EXIT_OPEN: begin
                if (outer_sensor && !inner_sensor) begin
                    state_d   = IDLE;
                    exit_done = 1'b1;
                end else if (timer_max) begin
                    state_d = TIMEOUT;
                end
            end
            TIMEOUT: begin
                if (!inner_sensor && !outer_sensor) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer restarts on any state change and only runs while a car is being served.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == WAIT_TICKET || state_q == EXIT_OPEN) && !timer_max) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        ticket_ready   = 1'b0;
        barrier_open   = 1'b0;
        green_LED      = 1'b0;
        red_LED        = 1'b0;
        display_screen = IDLE;
        case (state_q)
            WAIT_TICKET: begin
                ticket_ready   = 1'b1;
                display_screen = WAIT_TICKET;
            end
            REJECT: begin
                ticket_ready   = 1'b1;
                red_LED        = 1'b1;
                display_screen = REJECT;
            end
            EXIT_OPEN: begin
                barrier_open   = 1'b1;
                green_LED      = 1'b1;
                display_screen = EXIT_OPEN;
            end
            TIMEOUT: begin
                red_LED        = 1'b1;
                display_screen = TIMEOUT;
            end
            default: ;
        endcase
    end

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .OCC_W    (OCC_W)
    ) u_occupancy (
        .clock (clock),
        .reset (reset),
        .inc   (entry_event),
        .dec   (exit_done),
        .count (occupancy),
        .full  (lot_full),
        .empty (lot_empty)
    );

endmodule
